// File: rtl/sipo_deser_pkg.sv
// Shared types and constants for the sipo_deser serial deserializer.
// SIPO_PARITY_EN selects whether one even-parity bit trails each data word.
package sipo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

`ifdef SIPO_PARITY_EN
   localparam int unsigned PARITY_BITS = 1;
`else
   localparam int unsigned PARITY_BITS = 0;
`endif

   function automatic int unsigned clog2(input int unsigned x);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(x)) r++;
      return r;
   endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input, parallel output handshake and status bundle for sipo_deser.
// parity_err exists only when SIPO_PARITY_EN is defined.
interface sipo_deser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             ser_in;
   logic             ser_valid;
   logic             frame_start;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             overrun;
   logic             frame_err;
   logic             busy;
`ifdef SIPO_PARITY_EN
   logic             parity_err;
`endif

   modport master (
      output ser_in, ser_valid, frame_start, out_ready,
      input  out_data, out_valid, overrun, frame_err, busy
`ifdef SIPO_PARITY_EN
      , input parity_err
`endif
   );

   modport slave (
      input  ser_in, ser_valid, frame_start, out_ready,
      output out_data, out_valid, overrun, frame_err, busy
`ifdef SIPO_PARITY_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/sipo_deser_shift_core.sv
// Shift register and bit counter for sipo_deser: places each captured bit and
// flags the completing bit combinationally (SIPO_PARITY_EN adds a parity check).
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ser_in_i,
   input  logic             ser_valid_i,
   input  logic             frame_start_i,
   input  logic             shifting_i,
   output logic [WIDTH-1:0] word_o,
`ifdef SIPO_PARITY_EN
   output logic             parity_ok_o,
`endif
   output logic             done_o
);

   localparam int unsigned     CW       = clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH + PARITY_BITS - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] merged;
   logic             cap;

   // Indices at or beyond WIDTH (the parity bit) place nothing.
   function automatic logic [WIDTH-1:0] place(input int unsigned k, input logic b);
      logic [WIDTH-1:0] m;
      int unsigned      pos;
      m   = '0;
      pos = (MSB_FIRST != 0) ? (WIDTH - 1 - k) : k;
      if (k < WIDTH) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i == pos) m[i] = b;
         end
      end
      return m;
   endfunction

   always_comb begin
      cap     = ser_valid_i && (frame_start_i || shifting_i);
      merged  = shreg_q | place(32'(cnt_q), ser_in_i);
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      done_o  = 1'b0;
      if (cap) begin
         if (frame_start_i) begin
            shreg_d = place(0, ser_in_i);
            cnt_d   = CW'(1);
         end else if (cnt_q == LAST_IDX) begin
            done_o  = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            shreg_d = merged;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   assign word_o = merged;
`ifdef SIPO_PARITY_EN
   assign parity_ok_o = ((^shreg_q) == ser_in_i);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// Framed serial-in/parallel-out deserializer with valid/ready output and sticky
// overrun/framing flags; SIPO_PARITY_EN adds a trailing even-parity bit and parity_err.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 0
) (
   input logic          clk,
   input logic          reset,
   sipo_deser_if.slave  bus
);

   state_e           state_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_valid_q;
   logic             overrun_q;
   logic             frame_err_q;
   logic             busy_q;
   logic [WIDTH-1:0] word;
   logic             done;
   logic             word_good;
`ifdef SIPO_PARITY_EN
   logic             parity_ok;
   logic             parity_err_q;
`endif

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk           (clk),
      .reset         (reset),
      .ser_in_i      (bus.ser_in),
      .ser_valid_i   (bus.ser_valid),
      .frame_start_i (bus.frame_start),
      .shifting_i    (state_q == SHIFT),
      .word_o        (word),
`ifdef SIPO_PARITY_EN
      .parity_ok_o   (parity_ok),
`endif
      .done_o        (done)
   );

`ifdef SIPO_PARITY_EN
   assign word_good = done && parity_ok;
`else
   assign word_good = done;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         if (bus.ser_valid) begin
            case (state_q)
               IDLE: begin
                  if (bus.frame_start) begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (bus.frame_start) begin
                     frame_err_q <= 1'b1;
                  end else if (done) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end

         // A completing word takes priority over a plain consume; ready frees the slot.
         if (word_good) begin
            if (!out_valid_q || bus.out_ready) begin
               out_data_q  <= word;
               out_valid_q <= 1'b1;
            end else begin
               overrun_q   <= 1'b1;
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

`ifdef SIPO_PARITY_EN
         if (done && !parity_ok) parity_err_q <= 1'b1;
`endif
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;
`ifdef SIPO_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an 8-bit LSB-first and a 4-bit MSB-first instance.
// Parity vectors are added when SIPO_PARITY_EN is defined.
module tb_sipo_deser;

   logic clk;
   logic reset;
   int unsigned n_checks;
   int unsigned n_fail;

   sipo_deser_if #(.WIDTH(8)) bus8 ();
   sipo_deser_if #(.WIDTH(4)) bus4 ();

   sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) u8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) u4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick8(input logic b, input logic fs);
      bus8.ser_in      = b;
      bus8.ser_valid   = 1'b1;
      bus8.frame_start = fs;
      @(posedge clk);
      #1;
      bus8.ser_valid   = 1'b0;
      bus8.frame_start = 1'b0;
   endtask

   task automatic tick4(input logic b, input logic fs);
      bus4.ser_in      = b;
      bus4.ser_valid   = 1'b1;
      bus4.frame_start = fs;
      @(posedge clk);
      #1;
      bus4.ser_valid   = 1'b0;
      bus4.frame_start = 1'b0;
   endtask

   // LSB-first 8-bit word, framed on bit 0, followed by correct parity when enabled.
   task automatic send_word8(input logic [7:0] w);
      for (int i = 0; i < 8; i++) tick8(w[i], i == 0);
`ifdef SIPO_PARITY_EN
      tick8(^w, 1'b0);
`endif
   endtask

   initial begin
      logic seq4 [4];
      seq4 = '{1'b0, 1'b1, 1'b1, 1'b0};
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus8.ser_in = 1'b0; bus8.ser_valid = 1'b0; bus8.frame_start = 1'b0; bus8.out_ready = 1'b1;
      bus4.ser_in = 1'b0; bus4.ser_valid = 1'b0; bus4.frame_start = 1'b0; bus4.out_ready = 1'b1;
      idle();
      idle();

      check("rst_data",    32'(bus8.out_data),  32'h0);
      check("rst_valid",   32'(bus8.out_valid), 32'h0);
      check("rst_overrun", 32'(bus8.overrun),   32'h0);
      check("rst_ferr",    32'(bus8.frame_err), 32'h0);
      check("rst_busy",    32'(bus8.busy),      32'h0);
      reset = 1'b0;

      // LSB-first: bits 0,1,1,0,0,0,0,0 -> 8'h06
      send_word8(8'h06);
      check("lsb_valid", 32'(bus8.out_valid), 32'h1);
      check("lsb_data",  32'(bus8.out_data),  32'h06);
      check("lsb_busy",  32'(bus8.busy),      32'h0);
      idle();
      check("lsb_consumed", 32'(bus8.out_valid), 32'h0);
      check("lsb_hold",     32'(bus8.out_data),  32'h06);

      // MSB-first, WIDTH=4, one stall cycle after each bit
      for (int i = 0; i < 4; i++) begin
         tick4(seq4[i], i == 0);
         if (i < 3) begin
            check("msb_pending", 32'(bus4.out_valid), 32'h0);
            idle();
         end
      end
`ifdef SIPO_PARITY_EN
      idle();
      tick4(1'b0, 1'b0);
`endif
      check("msb_valid", 32'(bus4.out_valid), 32'h1);
      check("msb_data",  32'(bus4.out_data),  32'h6);
      idle();
      check("msb_consumed", 32'(bus4.out_valid), 32'h0);

      // Overrun: second word arrives while the first is unconsumed
      bus8.out_ready = 1'b0;
      send_word8(8'hA5);
      check("ovr_first_valid", 32'(bus8.out_valid), 32'h1);
      check("ovr_first_data",  32'(bus8.out_data),  32'hA5);
      check("ovr_clear",       32'(bus8.overrun),   32'h0);
      send_word8(8'h3C);
      check("ovr_data_kept", 32'(bus8.out_data),  32'hA5);
      check("ovr_set",       32'(bus8.overrun),   32'h1);
      check("ovr_valid",     32'(bus8.out_valid), 32'h1);
      bus8.out_ready = 1'b1;
      idle();
      check("ovr_drained", 32'(bus8.out_valid), 32'h0);
      check("ovr_sticky",  32'(bus8.overrun),   32'h1);

      // Framing error: restart after 3 bits, then 8'hFF
      tick8(1'b0, 1'b1);
      tick8(1'b1, 1'b0);
      tick8(1'b0, 1'b0);
      check("ferr_before", 32'(bus8.frame_err), 32'h0);
      tick8(1'b1, 1'b1);
      check("ferr_set",  32'(bus8.frame_err), 32'h1);
      check("ferr_busy", 32'(bus8.busy),      32'h1);
      for (int i = 1; i < 8; i++) tick8(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
      check("ferr_no_word", 32'(bus8.out_valid), 32'h0);
      tick8(1'b0, 1'b0);
`endif
      check("ferr_valid", 32'(bus8.out_valid), 32'h1);
      check("ferr_data",  32'(bus8.out_data),  32'hFF);
      idle();
      check("ferr_single_word", 32'(bus8.out_valid), 32'h0);

      // Reset mid-word
      for (int i = 0; i < 5; i++) tick8(1'b1, i == 0);
      check("mid_busy", 32'(bus8.busy), 32'h1);
      reset = 1'b1;
      idle();
      check("mrst_data",    32'(bus8.out_data),  32'h0);
      check("mrst_valid",   32'(bus8.out_valid), 32'h0);
      check("mrst_overrun", 32'(bus8.overrun),   32'h0);
      check("mrst_ferr",    32'(bus8.frame_err), 32'h0);
      check("mrst_busy",    32'(bus8.busy),      32'h0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick8(1'b1, 1'b0);
      check("unframed_busy",  32'(bus8.busy),      32'h0);
      check("unframed_valid", 32'(bus8.out_valid), 32'h0);
      send_word8(8'h81);
      check("post_rst_valid", 32'(bus8.out_valid), 32'h1);
      check("post_rst_data",  32'(bus8.out_data),  32'h81);
      idle();

`ifdef SIPO_PARITY_EN
      for (int i = 0; i < 8; i++) tick8(i < 3, i == 0);
      tick8(1'b1, 1'b0);
      check("par_good_valid", 32'(bus8.out_valid),  32'h1);
      check("par_good_data",  32'(bus8.out_data),   32'h07);
      check("par_good_flag",  32'(bus8.parity_err), 32'h0);
      idle();
      for (int i = 0; i < 8; i++) tick8(i < 3, i == 0);
      tick8(1'b0, 1'b0);
      check("par_bad_valid", 32'(bus8.out_valid),  32'h0);
      check("par_bad_flag",  32'(bus8.parity_err), 32'h1);
      check("par_bad_data",  32'(bus8.out_data),   32'h07);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserializer for the serial test path.
- Accepts one qualified bit per cycle, framed by a start marker, and assembles WIDTH-bit words in LSB-first or MSB-first order.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Reports overrun and framing errors.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = first received bit lands in out_data[0]; 1 = first received bit lands in out_data[WIDTH-1].

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in is valid this cycle.
- frame_start  in  1  qualified by ser_valid; marks the current bit as bit 0 of a new word.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- overrun  out  1  sticky: a completed word was dropped.
- frame_err  out  1  sticky: frame_start arrived mid-word.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset (synchronous) forces the following, regardless of other inputs:
  - state=IDLE, bit counter=0, shift register=0.
  - out_data=0, out_valid=0, overrun=0, frame_err=0, busy=0.
- The states are IDLE and SHIFT.
- IDLE:
  - Bits with ser_valid=1 and frame_start=0 are discarded.
  - ser_valid=1 and frame_start=1: capture the bit as bit 0, set counter=1, go to SHIFT.
- SHIFT:
  - Each ser_valid=1 cycle captures one bit and increments the counter.
  - ser_valid=0 cycles stall; there is no timeout.
- Bit placement:
  - LSB-first: bit k goes to position k.
  - MSB-first: bit k goes to position WIDTH-1-k.
- Word completion:
  - The cycle the bit with index WIDTH-1 is captured, the word is complete.
  - The FSM returns to IDLE and the counter goes to 0.
  - Each word needs its own frame_start.
- Output register update, on the clock edge after completion, so latency is 1 cycle from the last bit to out_valid=1:
  - out_valid=0, or out_valid=1 with out_ready=1: out_data loads the new word, out_valid=1.
  - out_valid=1 with out_ready=0: the new word is dropped, out_data is unchanged, overrun is set.
- Handshake:
  - out_valid=1 and out_ready=1 with no word completing: out_valid goes to 0 next cycle and out_data holds its value.
  - out_ready is ignored while out_valid=0.
- frame_start during SHIFT (ser_valid=1):
  - The partial word is abandoned and frame_err is set.
  - The current bit becomes bit 0 of a new word; counter=1, state stays SHIFT.
- Sticky flags: overrun and frame_err clear only on reset.
- busy=1 iff state=SHIFT.
- Bit counter width is clog2(WIDTH+1); it never exceeds WIDTH, so there is no wrap-around.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- When defined:
  - One extra bit follows the WIDTH data bits: even parity over the data bits.
  - The word completes on the parity bit; latency is measured from that bit.
  - Parity mismatch: the word is discarded (out_valid and out_data unchanged) and a sticky output port parity_err (1 bit, reset 0) is set.
  - Overrun checking applies only to words with good parity.
- When undefined:
  - No parity_err port.
  - The word completes after WIDTH bits.

Decomposition:
- Package sipo_pkg holds:
  - The state enum (IDLE, SHIFT).
  - The counter-width helper function (clog2).
  - The parity-bit-count constant, selected by SIPO_PARITY_EN.
- One sub-module, sipo_shift_core:
  - Holds the shift register, bit counter, ordering logic and the complete pulse.
  - The top level holds the FSM, output register, handshake and error flags.

Test Plan:
- LSB-first, WIDTH=8: frame_start on the first bit, bits 0,1,1,0,0,0,0,0 back-to-back, out_ready=1 -> out_data=8'h06 with out_valid=1 one cycle after the 8th bit, out_valid=0 the following cycle.
- MSB-first, WIDTH=4: bits 0,1,1,0 with ser_valid toggling every other cycle -> out_data=4'h6; stalls do not drop or duplicate bits.
- out_ready=0, two complete words 8'hA5 then 8'h3C -> out_data stays 8'hA5 and overrun=1. Then out_ready=1 -> out_valid=0 next cycle; overrun stays 1.
- frame_start reasserted after 3 bits, then 8 bits of 8'hFF -> frame_err=1, out_data=8'hFF, no word is emitted for the aborted frame.
- reset asserted mid-word (after 5 bits) -> all outputs 0 next cycle. Bits without frame_start are then ignored; a full framed word 8'h81 is received correctly.
- With SIPO_PARITY_EN: send 8'h07 with parity bit 1 -> out_data=8'h07. Send 8'h07 with parity bit 0 -> no out_valid, parity_err=1.
